alu_issue_queue: RTL and testbench

Command buffer and issue stage that sits directly upstream of the 32-bit combinational ALU. It accepts operation commands (in1, in2, sel) over a valid/ready handshake and queues them in a small FIFO. It presents the head command to the ALU, captures the ALU result in a registered response stage, and returns it downstream over a second valid/ready handshake. It decouples command producers from result consumers and keeps throughput at one operation per cycle.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 50 +++++
 rtl/alu_issue_queue.sv | 110 +++++++++++
 tb/tb_alu_issue_queue.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: operation encodings, the queued
// command record and the response-stage state type.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_ABSDIFF = 3'b001,
    ALU_OR      = 3'b010,
    ALU_AND     = 3'b011,
    ALU_XOR     = 3'b100,
    ALU_MUL     = 3'b101,
    ALU_ILLEGAL = 3'b110,
    ALU_EQ      = 3'b111
  } alu_sel_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] in1;
    logic [ALU_WIDTH-1:0] in2;
    alu_sel_e             sel;
  } alu_cmd_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; the head entry is
// visible combinationally so it can feed the ALU in the same cycle.
module alu_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // NOTE: storage is deliberately not reset; only pointers and count define
  // validity, which keeps the array as plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/alu_issue_queue.sv
// Command queue and issue stage in front of the combinational ALU: buffers
// commands, drives the ALU from the queue head and registers each result.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_in1,
  input  logic [WIDTH-1:0]       cmd_in2,
  input  logic [2:0]             cmd_sel,
  output logic [WIDTH-1:0]       alu_in1,
  output logic [WIDTH-1:0]       alu_in2,
  output logic [2:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_ans,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [2:0]             rsp_sel,
  output logic                   rsp_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CMD_W = $bits(alu_cmd_t);

  alu_cmd_t         w_push_cmd;
  alu_cmd_t         w_head;
  logic [CMD_W-1:0] w_head_bits;
  logic             w_push;
  logic             w_issue;
  logic             w_empty;
  logic             w_head_illegal;
  logic             w_drive;

  rsp_state_e       r_state;
  rsp_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_rsp_data;
  alu_sel_e         r_rsp_sel;
  logic             r_rsp_err;

  assign w_push_cmd = '{in1: cmd_in1, in2: cmd_in2, sel: alu_sel_e'(cmd_sel)};
  assign w_head     = alu_cmd_t'(w_head_bits);

  // cmd_ready comes from registered count only, so rsp_ready never reaches it.
  assign cmd_ready      = (count != CNT_W'(DEPTH));
  assign w_empty        = (count == '0);
  assign w_push         = cmd_valid && cmd_ready;
  assign w_issue        = !w_empty && (!rsp_valid || rsp_ready);
  assign w_head_illegal = (w_head.sel == ALU_ILLEGAL);
  assign w_drive        = !w_empty && !w_head_illegal;

  alu_cmd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_push_cmd),
    .i_pop   (w_issue),
    .o_head  (w_head_bits),
    .o_count (count)
  );

  // The ALU only ever sees a legal, live command; otherwise it idles on zeros.
  assign alu_in1 = w_drive ? w_head.in1 : '0;
  assign alu_in2 = w_drive ? w_head.in2 : '0;
  assign alu_sel = w_drive ? w_head.sel : ALU_ADD;

  // NOTE: state flops take non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RSP_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // NOTE: next state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RSP_EMPTY: if (w_issue) w_state_nxt = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !w_issue) w_state_nxt = RSP_EMPTY;
      default:   w_state_nxt = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data <= '0;
      r_rsp_sel  <= ALU_ADD;
      r_rsp_err  <= 1'b0;
    end else if (w_issue) begin
      r_rsp_data <= w_head_illegal ? '0 : alu_ans;
      r_rsp_sel  <= w_head.sel;
      r_rsp_err  <= w_head_illegal;
    end
  end

  assign rsp_valid = (r_state == RSP_FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_sel   = r_rsp_sel;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: a stand-in ALU, a queue-based reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_alu_issue_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_in1;
  logic [WIDTH-1:0] cmd_in2;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_ans;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_sel;
  logic             rsp_err;
  logic [CNT_W-1:0] count;

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_in1   (cmd_in1),
    .cmd_in2   (cmd_in2),
    .cmd_sel   (cmd_sel),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_sel   (alu_sel),
    .alu_ans   (alu_ans),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_sel   (rsp_sel),
    .rsp_err   (rsp_err),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0] s);
    case (s)
      3'b000:  return a + b;
      3'b001:  return (a > b) ? a - b : b - a;
      3'b010:  return a | b;
      3'b011:  return a & b;
      3'b100:  return a ^ b;
      3'b101:  return a * b;
      3'b111:  return (a == b) ? '1 : '0;
      default: return '0;
    endcase
  endfunction

  // Stand-in for the downstream combinational ALU.
  always_comb alu_ans = ref_alu(alu_in1, alu_in2, alu_sel);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       sel;
  } mcmd_t;

  mcmd_t            mq[$];
  mcmd_t            mc;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [2:0]       m_sel;
  logic             m_err;
  bit               m_push;
  bit               m_issue;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = '0;
      m_err   = 1'b0;
    end else begin
      m_push  = cmd_valid && (mq.size() != DEPTH);
      m_issue = (mq.size() != 0) && (!m_valid || rsp_ready);
      if (m_issue) begin
        mc      = mq.pop_front();
        m_valid = 1'b1;
        m_sel   = mc.sel;
        m_err   = (mc.sel == 3'b110);
        m_data  = ref_alu(mc.in1, mc.in2, mc.sel);
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
      if (m_push) mq.push_back('{in1: cmd_in1, in2: cmd_in2, sel: cmd_sel});
    end
  end

  bit               chk_en = 1'b0;
  logic [WIDTH-1:0] e_in1;
  logic [WIDTH-1:0] e_in2;
  logic [2:0]       e_sel;

  always @(negedge clk) begin
    if (chk_en) begin
      e_in1 = '0;
      e_in2 = '0;
      e_sel = '0;
      if (mq.size() != 0) begin
        if (mq[0].sel != 3'b110) begin
          e_in1 = mq[0].in1;
          e_in2 = mq[0].in2;
          e_sel = mq[0].sel;
        end
      end
      check("count",     count,     mq.size());
      check("cmd_ready", cmd_ready, mq.size() != DEPTH);
      check("rsp_valid", rsp_valid, m_valid);
      check("rsp_data",  rsp_data,  m_data);
      check("rsp_sel",   rsp_sel,   m_sel);
      check("rsp_err",   rsp_err,   m_err);
      check("alu_in1",   alu_in1,   e_in1);
      check("alu_in2",   alu_in2,   e_in2);
      check("alu_sel",   alu_sel,   e_sel);
    end
  end

  // ---------------- delivered-result log ----------------
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [2:0]       sel;
    logic             err;
    int               cyc;
  } rsp_t;

  rsp_t rlog[$];
  int   cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready)
      rlog.push_back('{data: rsp_data, sel: rsp_sel, err: rsp_err, cyc: cyc});
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] s);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_in1   = a;
    cmd_in2   = b;
    cmd_sel   = s;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while ((rsp_valid || count != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
    rlog.delete();
  endtask

  task automatic check_log(input string name, input int idx, input logic [WIDTH-1:0] data,
                           input logic [2:0] sel, input logic err);
    if (idx >= rlog.size()) begin
      check({name, "_missing"}, rlog.size(), idx + 1);
    end else begin
      check({name, "_data"}, rlog[idx].data, data);
      check({name, "_sel"},  rlog[idx].sel,  sel);
      check({name, "_err"},  rlog[idx].err,  err);
      if (idx > 0) check({name, "_gap"}, rlog[idx].cyc - rlog[idx-1].cyc, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int accepted;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_in1   = '0;
    cmd_in2   = '0;
    cmd_sel   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_count",     count,     0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_sel",   alu_sel,   0);
    check("rst_alu_in1",   alu_in1,   0);
    check("rst_rsp_data",  rsp_data,  0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // ADD then ABSDIFF back to back.
    wait_idle();
    send(32'd5, 32'd7, 3'b000);
    send(32'd3, 32'd10, 3'b001);
    repeat (4) @(posedge clk);
    #1;
    check("t1_n", rlog.size(), 2);
    check_log("t1_add", 0, 32'd12, 3'b000, 1'b0);
    check_log("t1_abs", 1, 32'd7,  3'b001, 1'b0);

    // MUL truncation and EQ.
    wait_idle();
    send(32'h0001_0000, 32'h0001_0000, 3'b101);
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b111);
    repeat (4) @(posedge clk);
    #1;
    check_log("t2_mul", 0, 32'h0000_0000, 3'b101, 1'b0);
    check_log("t2_eq",  1, 32'hFFFF_FFFF, 3'b111, 1'b0);

    // Illegal select parked at the head behind a stalled response.
    wait_idle();
    rsp_ready = 1'b0;
    send(32'd1, 32'd1, 3'b000);
    send(32'd9, 32'd4, 3'b110);
    repeat (3) begin
      @(negedge clk);
      check("t3_alu_sel", alu_sel, 0);
      check("t3_alu_in1", alu_in1, 0);
      check("t3_alu_in2", alu_in2, 0);
      check("t3_count",   count,   1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_log("t3_add", 0, 32'd2, 3'b000, 1'b0);
    check_log("t3_ill", 1, 32'd0, 3'b110, 1'b1);

    // Backpressure: six offers, five fit (DEPTH plus the response register).
    wait_idle();
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_in1   = 32'd100;
      cmd_in2   = 32'(i);
      cmd_sel   = 3'b000;
      @(negedge clk);
      if (cmd_ready) accepted++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("t4_accepted", accepted, 5);
    repeat (3) begin
      @(negedge clk);
      check("t4_count",     count,     4);
      check("t4_cmd_ready", cmd_ready, 0);
      check("t4_rsp_data",  rsp_data,  32'd100);
      check("t4_rsp_valid", rsp_valid, 1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t4_n", rlog.size(), 5);
    for (int k = 0; k < 5; k++) check_log("t4_drain", k, 32'(100 + k), 3'b000, 1'b0);

    // Steady push/pop at count 2 across several pointer wraps.
    wait_idle();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(32'd1000, 32'(k), 3'b000);
    rsp_ready = 1'b1;
    for (int k = 3; k < 15; k++) begin
      cmd_valid = 1'b1;
      cmd_in1   = 32'd1000;
      cmd_in2   = 32'(k);
      cmd_sel   = 3'b000;
      @(negedge clk);
      check("t5_count_steady", count, 2);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_n", rlog.size(), 15);
    for (int k = 0; k < 15; k++) check_log("t5_order", k, 32'(1000 + k), 3'b000, 1'b0);

    // Randomised traffic against the model.
    wait_idle();
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(3) != 0);
      rsp_ready = ($urandom_range(2) != 0);
      cmd_sel   = 3'($urandom_range(7));
      cmd_in1   = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
      cmd_in2   = ($urandom_range(3) == 0) ? cmd_in1 : $urandom;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;

    // Reset mid-stream with queued work and a pending response.
    wait_idle();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(32'(k), 32'd50, 3'b000);
    @(negedge clk);
    check("t7_pre_count", count,     3);
    check("t7_pre_valid", rsp_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_valid", rsp_valid, 0);
    check("t7_rst_count", count,     0);
    check("t7_rst_ready", cmd_ready, 1);
    check("t7_rst_alu",   alu_sel,   0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t7_no_stale", rlog.size(), 0);
    check("t7_idle",     rsp_valid,   0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
